bf16_add_unpack: RTL and testbench

BF16_ADD_UNPACK -- requirements
Module: bf16_add_unpack

---
 rtl/bf16_add_unpack.sv | 146 ++++++++++++++
 tb/tb_bf16_add_unpack.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/bf16_add_unpack.sv
// Front end of a BF16 adder: classifies and flushes operand pairs, resolves special
// cases into a bypass result, and buffers the unpacked pair in a 2-entry FIFO.

module bf16_add_unpack_cls #(
    parameter int E = 8,
    parameter int M = 7
) (
    input  logic [E+M:0] x,
    output logic         zero,
    output logic         inf,
    output logic         nan,
    output logic [E+M:0] ftz
);
    logic exp_ones, exp_zero, man_nz;

    assign exp_ones = &x[E+M-1:M];
    assign exp_zero = ~|x[E+M-1:M];
    assign man_nz   = |x[M-1:0];

    assign zero = exp_zero;
    assign inf  = exp_ones & ~man_nz;
    assign nan  = exp_ones & man_nz;
    // Subnormals flush to a signed zero; everything else passes untouched.
    assign ftz  = exp_zero ? {x[E+M], {(E+M){1'b0}}} : x;
endmodule

module bf16_add_unpack #(
    parameter int E = 8,
    parameter int M = 7
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [E+M:0]   a_i,
    input  logic [E+M:0]   b_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic           sa_o,
    output logic           sb_o,
    output logic [E-1:0]   ea_o,
    output logic [E-1:0]   eb_o,
    output logic [M-1:0]   ma_o,
    output logic [M-1:0]   mb_o,
    output logic           byp_o,
    output logic           byp_s_o,
    output logic [E-1:0]   byp_e_o,
    output logic [M-1:0]   byp_m_o,
    output logic [7:0]     spec_cnt_o
);
    localparam int W = 1 + E + M;
    localparam logic [W-1:0] QNAN = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};

    typedef struct packed {
        logic [1:0][W-1:0] fld;
        logic              byp;
        logic [W-1:0]      res;
    } entry_t;

    logic [1:0][W-1:0] ops, ftz;
    logic [1:0]        zero, inf, nan;
    entry_t            nxt, head;
    entry_t            mem [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        occ;
    logic [7:0]        spec_cnt;
    logic              push, pop;

    assign ops = {b_i, a_i};

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_cls
            bf16_add_unpack_cls #(.E(E), .M(M)) u_cls (
                .x    (ops[g]),
                .zero (zero[g]),
                .inf  (inf[g]),
                .nan  (nan[g]),
                .ftz  (ftz[g])
            );
        end
    endgenerate

    // Priority: NaN / opposing infs, then inf, then double zero, then single zero.
    always_comb begin
        nxt     = '0;
        nxt.fld = ftz;
        if (|nan || (&inf && (a_i[W-1] ^ b_i[W-1]))) begin
            nxt.byp = 1'b1;
            nxt.res = QNAN;
        end else if (inf[0]) begin
            nxt.byp = 1'b1;
            nxt.res = a_i;
        end else if (inf[1]) begin
            nxt.byp = 1'b1;
            nxt.res = b_i;
        end else if (&zero) begin
            nxt.byp = 1'b1;
            nxt.res = {a_i[W-1] & b_i[W-1], {(W-1){1'b0}}};
        end else if (zero[0]) begin
            nxt.byp = 1'b1;
            nxt.res = b_i;
        end else if (zero[1]) begin
            nxt.byp = 1'b1;
            nxt.res = a_i;
        end
    end

    // Handshakes depend only on registered occupancy, never on out_ready_i.
    assign in_ready_o  = (occ < 2'd2);
    assign out_valid_o = (occ != 2'd0);
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ      <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            spec_cnt <= '0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
            if (pop && head.byp && spec_cnt != 8'hFF)
                spec_cnt <= spec_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= nxt;
    end

    assign head = mem[rd_ptr];

    assign {sa_o, ea_o, ma_o} = head.fld[0];
    assign {sb_o, eb_o, mb_o} = head.fld[1];
    // Storage is not reset, so the flag is qualified to read 0 while empty.
    assign byp_o      = out_valid_o & head.byp;
    assign {byp_s_o, byp_e_o, byp_m_o} = head.res;
    assign spec_cnt_o = spec_cnt;
endmodule

// File: tb/tb_bf16_add_unpack.sv
// Scoreboarded bench for bf16_add_unpack: table vectors plus hand sequences for
// latency, backpressure, counter saturation and asynchronous reset.

module tb_bf16_add_unpack;
    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid_i = 1'b0, out_ready_i = 1'b0;
    logic [15:0] a_i = '0, b_i = '0;
    logic        in_ready_o, out_valid_o;
    logic        sa_o, sb_o, byp_o, byp_s_o;
    logic [7:0]  ea_o, eb_o, byp_e_o, spec_cnt_o;
    logic [6:0]  ma_o, mb_o, byp_m_o;

    bf16_add_unpack #(.E(8), .M(7)) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .a_i(a_i), .b_i(b_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .sa_o(sa_o), .sb_o(sb_o), .ea_o(ea_o), .eb_o(eb_o), .ma_o(ma_o), .mb_o(mb_o),
        .byp_o(byp_o), .byp_s_o(byp_s_o), .byp_e_o(byp_e_o), .byp_m_o(byp_m_o),
        .spec_cnt_o(spec_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a, b, fa, fb;
        logic        byp;
        logic [15:0] res;
    } vec_t;

    vec_t vecs [12];
    vec_t q [$];
    int   checks = 0, errors = 0;
    int   exp_cnt = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge: check the head against the scoreboard, then drive one cycle.
    task automatic cycle(input logic v, input vec_t e, input logic rdy);
        vec_t h;
        in_valid_i  = v;
        a_i         = e.a;
        b_i         = e.b;
        out_ready_i = rdy;
        chk("spec_cnt", {8'h00, spec_cnt_o}, exp_cnt[15:0]);
        if (out_valid_o) begin
            if (q.size() == 0) begin
                chk("spurious_valid", {15'd0, out_valid_o}, 16'd0);
            end else begin
                h = q[0];
                chk("byp",   {15'd0, byp_o}, {15'd0, h.byp});
                chk("fld_a", {sa_o, ea_o, ma_o}, h.fa);
                chk("fld_b", {sb_o, eb_o, mb_o}, h.fb);
                chk("res",   {byp_s_o, byp_e_o, byp_m_o}, h.res);
                if (rdy) begin
                    void'(q.pop_front());
                    if (h.byp && exp_cnt < 255) exp_cnt++;
                end
            end
        end
        if (v && in_ready_o) q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && q.size() > 0; k++) cycle(1'b0, vecs[0], 1'b1);
        chk("drain_left", q.size(), 16'd0);
        chk("empty_after_drain", {15'd0, out_valid_o}, 16'd0);
    endtask

    initial begin
        vec_t z, nz;
        vecs[0]  = '{16'h3F80, 16'h4000, 16'h3F80, 16'h4000, 1'b0, 16'h0000};
        vecs[1]  = '{16'h7F80, 16'hFF80, 16'h7F80, 16'hFF80, 1'b1, 16'h7FC0};
        vecs[2]  = '{16'h0001, 16'h3F80, 16'h0000, 16'h3F80, 1'b1, 16'h3F80};
        vecs[3]  = '{16'h7FC1, 16'h3F80, 16'h7FC1, 16'h3F80, 1'b1, 16'h7FC0};
        vecs[4]  = '{16'h7F80, 16'h3F80, 16'h7F80, 16'h3F80, 1'b1, 16'h7F80};
        vecs[5]  = '{16'h4000, 16'hFF80, 16'h4000, 16'hFF80, 1'b1, 16'hFF80};
        vecs[6]  = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b1, 16'h8000};
        vecs[7]  = '{16'h8000, 16'h0000, 16'h8000, 16'h0000, 1'b1, 16'h0000};
        vecs[8]  = '{16'hC040, 16'h807F, 16'hC040, 16'h8000, 1'b1, 16'hC040};
        vecs[9]  = '{16'h7F80, 16'h7F80, 16'h7F80, 16'h7F80, 1'b1, 16'h7F80};
        vecs[10] = '{16'hFF81, 16'h0000, 16'hFF81, 16'h0000, 1'b1, 16'h7FC0};
        vecs[11] = '{16'h3F80, 16'hBF80, 16'h3F80, 16'hBF80, 1'b0, 16'h0000};
        z  = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0000};
        nz = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b1, 16'h8000};

        #1;
        chk("rst_out_valid", {15'd0, out_valid_o}, 16'd0);
        chk("rst_in_ready",  {15'd0, in_ready_o},  16'd1);
        chk("rst_spec_cnt",  {8'd0, spec_cnt_o},   16'd0);
        chk("rst_byp",       {15'd0, byp_o},       16'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Push into empty FIFO: valid one cycle later.
        cycle(1'b1, vecs[0], 1'b1);
        chk("latency_valid", {15'd0, out_valid_o}, 16'd1);
        drain();

        // Table vectors with intermittent consumer stalls.
        for (int i = 0; i < 12; i++) cycle(1'b1, vecs[i], (i % 3) != 2);
        drain();

        // Backpressure: P0,P1 fill, P2 stalls, then freed slot used the cycle after the pop.
        cycle(1'b1, vecs[3], 1'b0);
        cycle(1'b1, vecs[0], 1'b0);
        chk("full_in_ready", {15'd0, in_ready_o}, 16'd0);
        cycle(1'b1, vecs[1], 1'b0);
        cycle(1'b1, vecs[1], 1'b0);
        chk("full_pop_in_ready", {15'd0, in_ready_o}, 16'd0);
        cycle(1'b1, vecs[1], 1'b1);
        chk("freed_in_ready", {15'd0, in_ready_o}, 16'd1);
        cycle(1'b1, vecs[1], 1'b1);
        drain();

        // Saturation of the bypass counter.
        for (int i = 0; i < 300; i++) cycle(1'b1, (i % 7 == 3) ? nz : z, 1'b1);
        drain();
        chk("spec_cnt_sat", {8'd0, spec_cnt_o}, 16'd255);

        // Asynchronous reset with a full FIFO.
        cycle(1'b1, vecs[0], 1'b0);
        cycle(1'b1, vecs[1], 1'b0);
        chk("prefill_full", {15'd0, in_ready_o}, 16'd0);
        in_valid_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", {15'd0, out_valid_o}, 16'd0);
        chk("arst_in_ready",  {15'd0, in_ready_o},  16'd1);
        chk("arst_spec_cnt",  {8'd0, spec_cnt_o},   16'd0);
        chk("arst_byp",       {15'd0, byp_o},       16'd0);
        q.delete();
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b0, vecs[0], 1'b1);
        cycle(1'b1, vecs[2], 1'b1);
        chk("post_rst_latency", {15'd0, out_valid_o}, 16'd1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
